// File: rtl/cond_eval4_pkg.sv
// Shared definitions for the condition-evaluation unit: condition codes,
// FSM state encoding and flag bit positions within the flag register.
package cond_eval4_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_ACK  = 2'd2,
    ST_WAIT = 2'd3
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_decode4.sv
// Purely combinational map from a condition code and {n,z,c,v} flags to a
// pass/fail result; shared by the query FSM and any future branch unit.
module cond_decode4
  import cond_eval4_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic [3:0] flags,
  output logic       cond_true
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    cond_true = 1'b0;
    case (cond_code)
      COND_EQ: cond_true = z;
      COND_NE: cond_true = !z;
      COND_CS: cond_true = c;
      COND_CC: cond_true = !c;
      COND_MI: cond_true = n;
      COND_PL: cond_true = !n;
      COND_VS: cond_true = v;
      COND_VC: cond_true = !v;
      COND_HI: cond_true = c & !z;
      COND_LS: cond_true = !c | z;
      COND_GE: cond_true = (n == v);
      COND_LT: cond_true = (n != v);
      COND_GT: cond_true = !z & (n == v);
      COND_LE: cond_true = z | (n != v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_eval4.sv
// Condition-evaluation unit: architectural NZCV register, four-phase
// condition-query handshake and saturating overflow event counter.
module cond_eval4
  import cond_eval4_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flag_we,
  input  logic             c_in,
  input  logic             n_in,
  input  logic             z_in,
  input  logic             v_in,
  input  logic             cond_req,
  input  logic [3:0]       cond_code,
  output logic             cond_ack,
  output logic             cond_true,
  output logic [3:0]       flags_out,
  output logic [CNT_W-1:0] v_cnt,
  input  logic             v_cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       flags_q, flags_d;
  logic             cond_true_q, cond_true_d;
  logic             cond_ack_q, cond_ack_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             dec_true;

  // Evaluates against the registered flags, so a write landing on the
  // acceptance edge is seen while a write during EVAL is not.
  cond_decode4 u_decode (
    .cond_code (code_q),
    .flags     (flags_q),
    .cond_true (dec_true)
  );

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    flags_d     = flags_q;
    cond_true_d = cond_true_q;
    cond_ack_d  = 1'b0;
    v_cnt_d     = v_cnt_q;

    if (flag_we) flags_d = {n_in, z_in, c_in, v_in};

    case (state_q)
      ST_IDLE: begin
        if (cond_req) begin
          code_d  = cond_code;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        cond_true_d = dec_true;
        state_d     = ST_ACK;
      end
      ST_ACK: begin
        cond_ack_d = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        if (!cond_req) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (v_cnt_clr) begin
      v_cnt_d = '0;
    end else if (flag_we && v_in && (v_cnt_q != CNT_MAX)) begin
      v_cnt_d = v_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      code_q      <= '0;
      flags_q     <= '0;
      cond_true_q <= 1'b0;
      cond_ack_q  <= 1'b0;
      v_cnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      flags_q     <= flags_d;
      cond_true_q <= cond_true_d;
      cond_ack_q  <= cond_ack_d;
      v_cnt_q     <= v_cnt_d;
    end
  end

  assign cond_ack  = cond_ack_q;
  assign cond_true = cond_true_q;
  assign flags_out = flags_q;
  assign v_cnt     = v_cnt_q;

endmodule

// File: tb/tb_cond_eval4.sv
// Scoreboard bench for cond_eval4: expected query results are queued when a
// request is driven and compared when cond_ack is observed.
module tb_cond_eval4;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flag_we;
  logic             c_in, n_in, z_in, v_in;
  logic             cond_req;
  logic [3:0]       cond_code;
  logic             cond_ack;
  logic             cond_true;
  logic [3:0]       flags_out;
  logic [CNT_W-1:0] v_cnt;
  logic             v_cnt_clr;

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;
  int ack_base = 0;

  logic       exp_q[$];
  logic [3:0] model_flags;
  int         model_cnt;

  cond_eval4 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flag_we   (flag_we),
    .c_in      (c_in),
    .n_in      (n_in),
    .z_in      (z_in),
    .v_in      (v_in),
    .cond_req  (cond_req),
    .cond_code (cond_code),
    .cond_ack  (cond_ack),
    .cond_true (cond_true),
    .flags_out (flags_out),
    .v_cnt     (v_cnt),
    .v_cnt_clr (v_cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference condition table, flags given as {n,z,c,v}.
  function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    unique case (code)
      4'd0:  return z;
      4'd1:  return ~z;
      4'd2:  return c;
      4'd3:  return ~c;
      4'd4:  return n;
      4'd5:  return ~n;
      4'd6:  return v;
      4'd7:  return ~v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n ~^ v;
      4'd11: return n ^ v;
      4'd12: return !z && (n ~^ v);
      4'd13: return z || (n ^ v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset_n === 1'b1 && cond_ack === 1'b1) begin
      ack_cnt++;
      if (exp_q.size() == 0) check("spurious_ack", 32'd1, 32'd0);
      else check("cond_true", {31'd0, cond_true}, {31'd0, exp_q.pop_front()});
    end
  end

  // One flag-register write (optionally with counter clear); checks the
  // flag register and counter one edge later.
  task automatic write_flags(input logic [3:0] nzcv, input logic clr);
    @(negedge clk);
    flag_we = 1'b1;
    {n_in, z_in, c_in, v_in} = nzcv;
    v_cnt_clr = clr;
    model_flags = nzcv;
    if (clr) model_cnt = 0;
    else if (nzcv[0] && model_cnt < (1 << CNT_W) - 1) model_cnt++;
    @(negedge clk);
    flag_we = 1'b0;
    v_cnt_clr = 1'b0;
    check("flags_out", {28'd0, flags_out}, {28'd0, model_flags});
    check("v_cnt", {28'd0, v_cnt}, model_cnt);
  endtask

  // Called at a negedge: raise the request and queue its expected result.
  task automatic start_req(input logic [3:0] code, input logic exp);
    cond_req  = 1'b1;
    cond_code = code;
    ack_base  = ack_cnt;
    exp_q.push_back(exp);
  endtask

  // Waits for the ack (bounded), checks latency, holds req, drops it and
  // checks that exactly one pulse was produced.
  task automatic complete_req(input int hold, input int already);
    int cyc;
    logic got;
    cyc = already;
    got = 1'b0;
    while (!got && cyc < 12) begin
      @(negedge clk);
      flag_we = 1'b0;
      cyc++;
      if (cond_ack === 1'b1) got = 1'b1;
    end
    check("ack_seen", {31'd0, got}, 32'd1);
    check("ack_latency", cyc, 3);
    repeat (hold) @(negedge clk);
    cond_req  = 1'b0;
    cond_code = 4'($urandom_range(0, 15));
    @(negedge clk);
    #1;
    check("ack_low", {31'd0, cond_ack}, 32'd0);
    check("ack_count", ack_cnt - ack_base, 1);
  endtask

  task automatic query(input logic [3:0] code, input int hold);
    @(negedge clk);
    start_req(code, ref_cond(code, model_flags));
    complete_req(hold, 0);
  endtask

  initial begin
    reset_n = 1'b0; flag_we = 1'b0; {n_in, z_in, c_in, v_in} = 4'b0;
    cond_req = 1'b0; cond_code = 4'd0; v_cnt_clr = 1'b0;
    model_flags = 4'b0; model_cnt = 0;
    repeat (2) @(negedge clk);
    check("rst_ack", {31'd0, cond_ack}, 32'd0);
    check("rst_true", {31'd0, cond_true}, 32'd0);
    check("rst_flags", {28'd0, flags_out}, 32'd0);
    check("rst_vcnt", {28'd0, v_cnt}, 32'd0);
    reset_n = 1'b1;

    // n=0 z=1 c=0 v=0: EQ true, NE false
    write_flags(4'b0100, 1'b0);
    query(4'd0, 0);
    check("eq_true", {31'd0, cond_true}, 32'd1);
    query(4'd1, 0);
    check("ne_false", {31'd0, cond_true}, 32'd0);

    // Same-edge forwarding of n=1 into LT; EVAL-cycle write ignored.
    @(negedge clk);
    flag_we = 1'b1; {n_in, z_in, c_in, v_in} = 4'b1000;
    start_req(4'd11, 1'b1);
    @(negedge clk);
    flag_we = 1'b1; {n_in, z_in, c_in, v_in} = 4'b0000;
    model_flags = 4'b0000;
    complete_req(0, 1);
    check("fwd_flags", {28'd0, flags_out}, 32'd0);
    query(4'd11, 0);

    // Signed codes sweep with n=1 v=1 z=0
    write_flags(4'b1001, 1'b0);
    for (int k = 10; k < 16; k++) query(4'(k), 0);

    // Random flags, all codes
    for (int r = 0; r < 3; r++) begin
      write_flags(4'($urandom_range(0, 15)) & 4'b1110, 1'b0);
      for (int k = 0; k < 16; k++) query(4'(k), 0);
    end

    // Request held for 10 cycles yields one ack
    query(4'd14, 10);

    // Counter saturation and clear priority
    write_flags(4'b0000, 1'b1);
    for (int k = 0; k < 17; k++) write_flags(4'b0001, 1'b0);
    check("vcnt_sat", {28'd0, v_cnt}, 32'd15);
    write_flags(4'b0001, 1'b1);
    check("vcnt_clr_prio", {28'd0, v_cnt}, 32'd0);
    write_flags(4'b0001, 1'b0);
    write_flags(4'b0001, 1'b0);

    // Reset mid-ACK with flags set to make EQ true beforehand
    write_flags(4'b0101, 1'b0);
    query(4'd0, 0);
    @(negedge clk);
    cond_req = 1'b1; cond_code = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    model_flags = 4'b0; model_cnt = 0;
    check("mid_rst_ack", {31'd0, cond_ack}, 32'd0);
    check("mid_rst_true", {31'd0, cond_true}, 32'd0);
    check("mid_rst_flags", {28'd0, flags_out}, 32'd0);
    check("mid_rst_vcnt", {28'd0, v_cnt}, 32'd0);
    // Held request accepted as new one after reset release
    reset_n = 1'b1;
    start_req(4'd1, 1'b1);
    complete_req(0, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
